// File: rtl/frame_buffer_rd_pkg.sv
// Shared types, constants and helpers for the frame-buffer read scheduler.
// The 4 KiB constant is only consumed when FB_RD_4K_SPLIT_EN is defined.
package frame_buffer_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_FIFO,
        ST_CMD,
        ST_LINE_END
    } state_e;

    localparam int C_DATA_BYTES = 32;
    localparam int C_4K_BYTES   = 4096;

    // Clamp a to the upper bound b.
    function automatic logic [18:0] f_upper(input logic [18:0] a, input logic [18:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [18:0] f_ceil_div(input logic [18:0] num, input logic [18:0] den);
        logic [19:0] sum;
        sum = {1'b0, num} + {1'b0, den} - 20'd1;
        return 19'(sum / {1'b0, den});
    endfunction

endpackage

// File: rtl/fb_rd_burst_calc.sv
// Combinational burst sizing and next-address step for one read command.
// With FB_RD_4K_SPLIT_EN defined, bursts are also clipped at 4 KiB boundaries.
module fb_rd_burst_calc
    import frame_buffer_rd_pkg::*;
#(
    parameter int C_ADDR_WIDTH    = 32,
    parameter int C_BYTES         = C_DATA_BYTES,
    parameter int C_MAX_BURST_LEN = 64
) (
    input  logic [18:0]             remaining_i,
    input  logic [C_ADDR_WIDTH-1:0] addr_i,
    output logic [18:0]             burst_o,
    output logic [C_ADDR_WIDTH-1:0] next_addr_o
);

`ifdef FB_RD_4K_SPLIT_EN
    logic [18:0] to_4k_w;
    // Base and stride are beat aligned, so this is always at least one beat.
    assign to_4k_w = 19'((C_4K_BYTES - int'(addr_i[11:0])) / C_BYTES);
    assign burst_o = f_upper(f_upper(remaining_i, 19'(C_MAX_BURST_LEN)), to_4k_w);
`else
    assign burst_o = f_upper(remaining_i, 19'(C_MAX_BURST_LEN));
`endif

    assign next_addr_o = addr_i + C_ADDR_WIDTH'(burst_o) * C_ADDR_WIDTH'(C_BYTES);

endmodule

// File: rtl/frame_buffer_rd_scheduler.sv
// Frame-buffer read command scheduler: walks each frame line by line, issuing
// FIFO-throttled AXI4 read bursts. Optional macro: FB_RD_4K_SPLIT_EN.
module frame_buffer_rd_scheduler
    import frame_buffer_rd_pkg::*;
#(
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = C_DATA_BYTES * 8,
    parameter int C_MAX_BURST_LEN  = 64,
    parameter int C_FIFO_DEPTH     = 512,
    parameter int C_FIFO_CNT_WIDTH = 10
) (
    input  logic                        AXI4_CLK_I,
    input  logic                        AXI4_RSTN_I,
    input  logic                        ENABLE_I,
    input  logic                        FRAME_START_I,
    input  logic [C_ADDR_WIDTH-1:0]     BASE_ADDR_I,
    input  logic [C_ADDR_WIDTH-1:0]     STRIDE_I,
    input  logic [15:0]                 HACTIVE_I,
    input  logic [15:0]                 VACTIVE_I,
    input  logic [2:0]                  MEM_BYTES_I,
    input  logic [C_FIFO_CNT_WIDTH-1:0] FIFO_CNT_I,
    input  logic                        RD_BEAT_I,
    output logic                        CMD_VALID_O,
    input  logic                        CMD_READY_I,
    output logic [C_ADDR_WIDTH-1:0]     CMD_ADDR_O,
    output logic [7:0]                  CMD_LEN_O,
    output logic                        LINE_DONE_O,
    output logic                        FRAME_DONE_O,
    output logic                        BUSY_O,
    output logic                        ERR_RESTART_O
);

    localparam int LP_BYTES = C_DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    rst_pend_q, rst_pend_d;
    logic                    err_q, err_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [C_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]              cmd_len_q, cmd_len_d;
    logic [15:0]             line_q, line_d;
    logic [18:0]             remaining_q, remaining_d;
    logic [18:0]             bpl_q, bpl_d;
    logic [15:0]             outst_q, outst_d;
    logic [C_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [C_ADDR_WIDTH-1:0] base_q, stride_q;
    logic [15:0]             hact_q, vact_q;
    logic [2:0]              mem_q;

    logic [18:0]             burst_w;
    logic [C_ADDR_WIDTH-1:0] next_addr_w;
    logic [19:0]             need_w;
    logic                    accept_w, restart_w, beat_w, line_done_w, frame_done_w;

    fb_rd_burst_calc #(
        .C_ADDR_WIDTH    (C_ADDR_WIDTH),
        .C_BYTES         (LP_BYTES),
        .C_MAX_BURST_LEN (C_MAX_BURST_LEN)
    ) u_burst_calc (
        .remaining_i (remaining_q),
        .addr_i      (addr_q),
        .burst_o     (burst_w),
        .next_addr_o (next_addr_w)
    );

    assign accept_w     = cmd_valid_q && CMD_READY_I;
    assign restart_w    = FRAME_START_I && (state_q != ST_IDLE);
    assign beat_w       = RD_BEAT_I && (outst_q != 16'd0);
    assign need_w       = 20'(FIFO_CNT_I) + 20'(outst_q) + 20'(burst_w);
    assign line_done_w  = (state_q == ST_LINE_END) && ENABLE_I;
    assign frame_done_w = line_done_w && ((line_q + 16'd1) == vact_q);

    always_comb begin
        state_d     = state_q;
        rst_pend_d  = rst_pend_q;
        err_d       = 1'b0;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        line_d      = line_q;
        remaining_d = remaining_q;
        bpl_d       = bpl_q;
        line_addr_d = line_addr_q;
        addr_d      = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (FRAME_START_I && ENABLE_I && (HACTIVE_I != 16'd0) && (VACTIVE_I != 16'd0))
                    state_d = ST_CALC;
            end
            ST_CALC: begin
                bpl_d       = f_ceil_div(19'(hact_q) * 19'(mem_q), 19'(LP_BYTES));
                remaining_d = bpl_d;
                line_d      = 16'd0;
                line_addr_d = base_q;
                addr_d      = base_q;
                state_d     = ST_WAIT_FIFO;
            end
            ST_WAIT_FIFO: begin
                if (!ENABLE_I) begin
                    state_d = ST_IDLE;
                end else if (need_w <= 20'(C_FIFO_DEPTH)) begin
                    state_d     = ST_CMD;
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = addr_q;
                    cmd_len_d   = 8'(burst_w - 19'd1);
                end
            end
            ST_CMD: begin
                // A restart seen mid-handshake is parked until the command is taken.
                if (restart_w && !accept_w)
                    rst_pend_d = 1'b1;
                if (accept_w) begin
                    cmd_valid_d = 1'b0;
                    addr_d      = next_addr_w;
                    remaining_d = remaining_q - burst_w;
                    if (restart_w || rst_pend_q) begin
                        err_d      = 1'b1;
                        rst_pend_d = 1'b0;
                        state_d    = ST_CALC;
                    end else if (remaining_d == 19'd0) begin
                        state_d = ST_LINE_END;
                    end else begin
                        state_d = ST_WAIT_FIFO;
                    end
                end
            end
            ST_LINE_END: begin
                if (!ENABLE_I || frame_done_w) begin
                    state_d = ST_IDLE;
                end else begin
                    line_d      = line_q + 16'd1;
                    line_addr_d = line_addr_q + stride_q;
                    addr_d      = line_addr_q + stride_q;
                    remaining_d = bpl_q;
                    state_d     = ST_WAIT_FIFO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (restart_w && (state_q != ST_CMD)) begin
            err_d       = 1'b1;
            cmd_valid_d = 1'b0;
            state_d     = ST_CALC;
        end
    end

    // Outstanding beats never underflow; a beat at zero is dropped.
    assign outst_d = outst_q + (accept_w ? 16'(burst_w) : 16'd0) - (beat_w ? 16'd1 : 16'd0);

    always_ff @(posedge AXI4_CLK_I or negedge AXI4_RSTN_I) begin
        if (!AXI4_RSTN_I) begin
            state_q     <= ST_IDLE;
            rst_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= 8'd0;
            line_q      <= 16'd0;
            remaining_q <= 19'd0;
            bpl_q       <= 19'd0;
            outst_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            rst_pend_q  <= rst_pend_d;
            err_q       <= err_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            line_q      <= line_d;
            remaining_q <= remaining_d;
            bpl_q       <= bpl_d;
            outst_q     <= outst_d;
        end
    end

    always_ff @(posedge AXI4_CLK_I) begin
        line_addr_q <= line_addr_d;
        addr_q      <= addr_d;
        if (FRAME_START_I) begin
            base_q   <= BASE_ADDR_I;
            stride_q <= STRIDE_I;
            hact_q   <= HACTIVE_I;
            vact_q   <= VACTIVE_I;
            mem_q    <= MEM_BYTES_I;
        end
    end

    assign CMD_VALID_O   = cmd_valid_q;
    assign CMD_ADDR_O    = cmd_addr_q;
    assign CMD_LEN_O     = cmd_len_q;
    assign LINE_DONE_O   = line_done_w;
    assign FRAME_DONE_O  = frame_done_w;
    assign BUSY_O        = (state_q != ST_IDLE);
    assign ERR_RESTART_O = err_q;

endmodule

// File: doc/frame_buffer_rd_scheduler.md
Name: frame_buffer_rd_scheduler

Overview:
Read-side command scheduler for the frame-buffer read datapath. On each frame start it walks the active frame line by line and issues AXI4 read burst commands (address, length) to the AXI4 master. It throttles issue against the pixel FIFO fill level plus in-flight beats, so the FIFO can never overflow. It sits between the video-timing frame-start event and the AXI4 read master, in the AXI4 clock domain.

Parameters:
- C_ADDR_WIDTH, 32: byte address width.
- C_DATA_WIDTH, 256: AXI4 data width in bits; C_DATA_BYTES = C_DATA_WIDTH/8.
- C_MAX_BURST_LEN, 64: maximum beats per command, 1..256.
- C_FIFO_DEPTH, 512: pixel FIFO depth in beats.
- C_FIFO_CNT_WIDTH, 10: width of the FIFO count input.

Ports:
- AXI4_CLK_I  in  1  clock.
- AXI4_RSTN_I  in  1  asynchronous active-low reset.
- ENABLE_I  in  1  scheduler enable.
- FRAME_START_I  in  1  single-cycle pulse, already synchronised into this domain.
- BASE_ADDR_I  in  C_ADDR_WIDTH  frame base byte address.
- STRIDE_I  in  C_ADDR_WIDTH  line pitch in bytes.
- HACTIVE_I  in  16  pixels per line.
- VACTIVE_I  in  16  lines per frame.
- MEM_BYTES_I  in  3  bytes per pixel in memory, 1..4.
- FIFO_CNT_I  in  C_FIFO_CNT_WIDTH  FIFO occupied beats.
- RD_BEAT_I  in  1  one read beat written into the FIFO.
- CMD_VALID_O  out  1  command valid.
- CMD_READY_I  in  1  command accepted by the master.
- CMD_ADDR_O  out  C_ADDR_WIDTH  burst start byte address.
- CMD_LEN_O  out  8  beats-1 (AXI ARLEN encoding).
- LINE_DONE_O  out  1  pulse: last command of the line accepted.
- FRAME_DONE_O  out  1  pulse: last command of the frame accepted.
- BUSY_O  out  1  frame in progress.
- ERR_RESTART_O  out  1  pulse: frame start arrived while a frame was in progress.

Behaviour:
- Reset: all outputs 0; state IDLE; line counter, beat counters and outstanding counter 0.
- States are IDLE → CALC → WAIT_FIFO → CMD → (WAIT_FIFO | LINE_END) → (WAIT_FIFO | IDLE).
- IDLE:
  - On FRAME_START_I with ENABLE_I=1, shadow-latch BASE, STRIDE, HACTIVE, VACTIVE and MEM_BYTES.
  - Set BUSY_O and go to CALC.
  - If HACTIVE or VACTIVE is 0, stay in IDLE.
- CALC (1 cycle):
  - beats_per_line = ceil(HACTIVE*MEM_BYTES / C_DATA_BYTES), using a 19-bit product.
  - line_addr = BASE; line = 0; remaining = beats_per_line.
- WAIT_FIFO:
  - burst = min(remaining, C_MAX_BURST_LEN).
  - Go to CMD when FIFO_CNT_I + outstanding + burst <= C_FIFO_DEPTH.
- CMD:
  - CMD_VALID_O is registered and rises the cycle after entry.
  - CMD_ADDR_O and CMD_LEN_O are stable while VALID=1 && READY=0.
  - On VALID && READY:
    - outstanding += burst; addr += burst*C_DATA_BYTES; remaining -= burst.
    - If remaining == 0, go to LINE_END; otherwise go to WAIT_FIFO.
- LINE_END (1 cycle):
  - Pulse LINE_DONE_O; line += 1; line_addr += STRIDE.
  - If line == VACTIVE: pulse FRAME_DONE_O in the same cycle, clear BUSY_O, go to IDLE.
  - Otherwise reload remaining and go to WAIT_FIFO.
- Outstanding counter:
  - Decrements by 1 on each RD_BEAT_I.
  - Accept and beat in the same cycle: outstanding += burst-1.
  - RD_BEAT_I at outstanding = 0 is ignored (no underflow).
- FRAME_START_I while BUSY_O=1 (any state other than IDLE):
  - Pulse ERR_RESTART_O, re-latch the shadow registers, go to CALC.
  - If in CMD with VALID=1 and READY=0: VALID is held until the handshake completes, then the restart is taken.
  - Outstanding is not cleared.
- ENABLE_I deasserted:
  - The current handshake completes.
  - The scheduler then returns to IDLE at the next WAIT_FIFO or LINE_END without a done pulse, and BUSY_O=0.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH.

Optional Feature:
- Macro: FB_RD_4K_SPLIT_EN.
- With the macro defined, burst = min(remaining, C_MAX_BURST_LEN, (4096 - addr[11:0]) / C_DATA_BYTES), so no burst crosses a 4 KiB boundary.
  - Requires BASE and STRIDE aligned to C_DATA_BYTES.
- Without it, the 4 KiB term is omitted and the caller guarantees alignment.

Decomposition:
- Package frame_buffer_rd_pkg holds:
  - the state enum;
  - C_DATA_BYTES;
  - the 4 KiB constant;
  - the f_upper and ceil-div functions.
- One sub-module, fb_rd_burst_calc, is natural: combinational burst-size and next-address calculation, including the 4K split.

Test Plan:
- HACTIVE=256, MEM=4, VACTIVE=128, BASE=0, STRIDE=1024, READY=1, FIFO_CNT=0 → 128 commands, each LEN=31, ADDR=n*1024; LINE_DONE ×128; one FRAME_DONE.
- HACTIVE=1920, MEM=4 → 240 beats/line → per-line LEN sequence 63,63,63,47, addresses +2048 per burst.
- Depth 512, outstanding 0, burst 32: FIFO_CNT=481 → VALID stays 0; drop FIFO_CNT to 480 → VALID=1 the next cycle.
- FRAME_START at line 5 with READY=0 in CMD → VALID held, ERR_RESTART pulse after acceptance, next ADDR=BASE.
- FB_RD_4K_SPLIT_EN, BASE=0x0F80, 32-beat line → LEN=3 at 0x0F80, then LEN=27 at 0x1000.
- Reset mid-burst, and ENABLE_I=0 mid-frame → all outputs 0 immediately on reset; on disable, BUSY falls after the current handshake with no FRAME_DONE.
